// File: rtl/hpdcache_arb_mux.sv
// N-input arbitrated mux with valid/ready handshakes, multi-beat grant locking
// and a one-entry registered output stage carrying payload, last flag and one-hot source.
module hpdcache_arb_mux #(
    parameter int unsigned NINPUT     = 2,
    parameter int unsigned DATA_WIDTH = 64,
    parameter bit          RR_ARB     = 1'b1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NINPUT-1:0]                    req_valid_i,
    output logic [NINPUT-1:0]                    req_ready_o,
    input  logic [NINPUT-1:0][DATA_WIDTH-1:0]    req_data_i,
    input  logic [NINPUT-1:0]                    req_last_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [DATA_WIDTH-1:0]                out_data_o,
    output logic                                 out_last_o,
    output logic [NINPUT-1:0]                    out_sel_o
);

    localparam int unsigned PW = (NINPUT > 1) ? $clog2(NINPUT) : 1;

    logic [PW-1:0]     ptr;
    logic [PW-1:0]     lock_idx;
    logic              lock;
    logic [PW-1:0]     winner;
    logic [PW-1:0]     ptr_next;
    logic [PW-1:0]     scan_idx;
    logic              found;
    logic              load_en;
    logic              accept;
    logic [NINPUT-1:0] cand;
    logic [NINPUT-1:0] lock_mask;
    logic [NINPUT-1:0] win_onehot;
    int unsigned       scan;

    always_comb begin
        lock_mask  = '0;
        win_onehot = '0;
        found      = 1'b0;
        winner     = '0;
        scan       = 0;
        scan_idx   = '0;

        for (int unsigned i = 0; i < NINPUT; i++) begin
            lock_mask[i] = (lock_idx == PW'(i));
        end
        cand = lock ? (req_valid_i & lock_mask) : req_valid_i;

        // Rotating scan starts at ptr; fixed priority always starts at 0.
        // The wrap is done at NINPUT, not at 2^PW.
        for (int unsigned i = 0; i < NINPUT; i++) begin
            scan = i;
            if (RR_ARB) scan = i + 32'(ptr);
            if (scan >= NINPUT) scan = scan - NINPUT;
            scan_idx = PW'(scan);
            if (!found && cand[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end

        load_en = !out_valid_o || out_ready_i;
        accept  = load_en && found;
        if (found) win_onehot[winner] = 1'b1;
        req_ready_o = accept ? win_onehot : '0;
        ptr_next    = (winner == PW'(NINPUT - 1)) ? '0 : winner + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_last_o  <= 1'b0;
            out_sel_o   <= '0;
            ptr         <= '0;
            lock        <= 1'b0;
            lock_idx    <= '0;
        end else if (load_en) begin
            if (accept) begin
                out_valid_o <= 1'b1;
                out_data_o  <= req_data_i[winner];
                out_last_o  <= req_last_i[winner];
                out_sel_o   <= win_onehot;
                if (req_last_i[winner]) begin
                    lock <= 1'b0;
                    // Only completed transfers advance fairness.
                    if (RR_ARB) ptr <= ptr_next;
                end else begin
                    lock     <= 1'b1;
                    lock_idx <= winner;
                end
            end else begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hpdcache_arb_mux.sv
// Scoreboard bench: a fixed-priority 4-input mux and a round-robin 5-input mux driven
// in lockstep against a behavioural arbitration model.
module tb_hpdcache_arb_mux;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0]          a_valid, a_ready, a_last, a_sel;
    logic [3:0][DW-1:0]  a_data;
    logic                a_ovalid, a_oready, a_olast;
    logic [DW-1:0]       a_odata;

    logic [4:0]          b_valid, b_ready, b_last, b_sel;
    logic [4:0][DW-1:0]  b_data;
    logic                b_ovalid, b_oready, b_olast;
    logic [DW-1:0]       b_odata;

    hpdcache_arb_mux #(.NINPUT(4), .DATA_WIDTH(DW), .RR_ARB(1'b0)) u_a (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(a_valid), .req_ready_o(a_ready), .req_data_i(a_data), .req_last_i(a_last),
        .out_valid_o(a_ovalid), .out_ready_i(a_oready), .out_data_o(a_odata),
        .out_last_o(a_olast), .out_sel_o(a_sel)
    );

    hpdcache_arb_mux #(.NINPUT(5), .DATA_WIDTH(DW), .RR_ARB(1'b1)) u_b (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(b_valid), .req_ready_o(b_ready), .req_data_i(b_data), .req_last_i(b_last),
        .out_valid_o(b_ovalid), .out_ready_i(b_oready), .out_data_o(b_odata),
        .out_last_o(b_olast), .out_sel_o(b_sel)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [7:0]    sel;
    } beat_t;

    int n_vec = 0;
    int n_err = 0;
    beat_t q_a[$];
    beat_t q_b[$];
    beat_t cur[2];
    int    m_ptr[2];
    int    m_lock[2];
    int    m_lidx[2];
    bit    m_ov[2];
    logic [7:0] cyc = 8'd0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mkdata(input int id, input int k);
        logic [7:0] base;
        base = (id == 0) ? 8'hA0 : 8'hB0;
        return {cyc, base + 8'(k)};
    endfunction

    task automatic predict(input int id, input int n, input bit rr, input logic [7:0] v,
                           input bit ordy, output int win, output bit ld);
        ld  = !m_ov[id] || ordy;
        win = -1;
        for (int i = 0; i < n; i++) begin
            int idx;
            idx = rr ? (m_ptr[id] + i) % n : i;
            if (win < 0 && v[idx] && (m_lock[id] == 0 || idx == m_lidx[id])) win = idx;
        end
    endtask

    task automatic commit(input int id, input int n, input bit rr, input logic [7:0] l,
                          input int win, input bit ld);
        beat_t b;
        if (!ld) return;
        if (win < 0) begin
            m_ov[id] = 1'b0;
            return;
        end
        b.data = mkdata(id, win);
        b.last = l[win];
        b.sel  = 8'(1 << win);
        if (id == 0) q_a.push_back(b);
        else         q_b.push_back(b);
        m_ov[id] = 1'b1;
        if (l[win]) begin
            m_lock[id] = 0;
            if (rr) m_ptr[id] = (win + 1) % n;
        end else begin
            m_lock[id] = 1;
            m_lidx[id] = win;
        end
    endtask

    task automatic step(input logic [3:0] av, input logic [3:0] al, input bit aor,
                        input logic [4:0] bv, input logic [4:0] bl, input bit bor);
        int wa, wb;
        bit la, lb;
        beat_t e;
        @(negedge clk);
        cyc = cyc + 8'd1;
        a_valid = av; a_last = al; a_oready = aor;
        b_valid = bv; b_last = bl; b_oready = bor;
        for (int k = 0; k < 4; k++) a_data[k] = mkdata(0, k);
        for (int k = 0; k < 5; k++) b_data[k] = mkdata(1, k);
        #1;
        predict(0, 4, 1'b0, 8'(av), aor, wa, la);
        predict(1, 5, 1'b1, 8'(bv), bor, wb, lb);
        check("a_ready", 32'(a_ready), (la && wa >= 0) ? 32'(1 << wa) : 32'd0);
        check("b_ready", 32'(b_ready), (lb && wb >= 0) ? 32'(1 << wb) : 32'd0);
        @(posedge clk);
        #1;
        commit(0, 4, 1'b0, 8'(al), wa, la);
        commit(1, 5, 1'b1, 8'(bl), wb, lb);

        check("a_ovalid", 32'(a_ovalid), 32'(m_ov[0]));
        if (la && wa >= 0) begin
            e = q_a.pop_front();
            cur[0] = e;
            check("a_data", 32'(a_odata), 32'(e.data));
            check("a_last", 32'(a_olast), 32'(e.last));
            check("a_sel",  32'(a_sel),   32'(e.sel));
        end else if (m_ov[0]) begin
            check("a_hold_data", 32'(a_odata), 32'(cur[0].data));
            check("a_hold_sel",  32'(a_sel),   32'(cur[0].sel));
        end

        check("b_ovalid", 32'(b_ovalid), 32'(m_ov[1]));
        if (lb && wb >= 0) begin
            e = q_b.pop_front();
            cur[1] = e;
            check("b_data", 32'(b_odata), 32'(e.data));
            check("b_last", 32'(b_olast), 32'(e.last));
            check("b_sel",  32'(b_sel),   32'(e.sel));
        end else if (m_ov[1]) begin
            check("b_hold_data", 32'(b_odata), 32'(cur[1].data));
            check("b_hold_sel",  32'(b_sel),   32'(cur[1].sel));
        end
        check("b_ptr", 32'(u_b.ptr), 32'(m_ptr[1]));
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("rst_a_ovalid", 32'(a_ovalid), 32'd0);
        check("rst_b_ovalid", 32'(b_ovalid), 32'd0);
        check("rst_a_data",   32'(a_odata),  32'd0);
        check("rst_b_sel",    32'(b_sel),    32'd0);
        check("rst_b_last",   32'(b_olast),  32'd0);
        check("rst_b_ptr",    32'(u_b.ptr),  32'd0);
        for (int i = 0; i < 2; i++) begin
            m_ptr[i] = 0; m_lock[i] = 0; m_lidx[i] = 0; m_ov[i] = 1'b0;
        end
        q_a.delete();
        q_b.delete();
        a_valid = '0; b_valid = '0; a_oready = 1'b1; b_oready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        a_valid = '0; a_last = '0; a_oready = 1'b1; a_data = '0;
        b_valid = '0; b_last = '0; b_oready = 1'b1; b_data = '0;
        #3;
        apply_reset();

        // fixed priority under full contention
        repeat (4) step(4'hF, 4'hF, 1'b1, 5'h00, 5'h00, 1'b1);

        // round-robin fairness with wrap from 4 to 0
        repeat (6) step(4'h0, 4'h0, 1'b1, 5'h1F, 5'h1F, 1'b1);

        // lock: input 2 sends three beats while input 0 waits
        step(4'h0, 4'h0, 1'b1, 5'b00101, 5'b00001, 1'b1);
        step(4'h0, 4'h0, 1'b1, 5'b00101, 5'b00001, 1'b1);
        step(4'h0, 4'h0, 1'b1, 5'b00101, 5'b00101, 1'b1);
        step(4'h0, 4'h0, 1'b1, 5'b00001, 5'b00001, 1'b1);

        // lock under fixed priority overrides the lower index
        step(4'b1000, 4'b0000, 1'b1, 5'h00, 5'h00, 1'b1);
        step(4'b1001, 4'b0001, 1'b1, 5'h00, 5'h00, 1'b1);
        step(4'b1001, 4'b1001, 1'b1, 5'h00, 5'h00, 1'b1);
        step(4'b0001, 4'b0001, 1'b1, 5'h00, 5'h00, 1'b1);

        // backpressure for five cycles, then no-bubble acceptance
        step(4'b0010, 4'b0010, 1'b1, 5'b00010, 5'b00010, 1'b1);
        repeat (5) step(4'b0010, 4'b0010, 1'b0, 5'b00010, 5'b00010, 1'b0);
        step(4'b0010, 4'b0010, 1'b1, 5'b00010, 5'b00010, 1'b1);
        step(4'h0, 4'h0, 1'b1, 5'h00, 5'h00, 1'b1);

        // last beat from input 4 wraps the pointer to 0
        step(4'h0, 4'h0, 1'b1, 5'b10000, 5'b10000, 1'b1);
        step(4'h0, 4'h0, 1'b1, 5'b00110, 5'b00110, 1'b1);

        repeat (60) step(4'($urandom), 4'($urandom) | 4'($urandom), ($urandom_range(0, 3) != 0),
                         5'($urandom), 5'($urandom) | 5'($urandom), ($urandom_range(0, 3) != 0));

        // release any lock left by the random phase, then reset inside a locked transfer
        step(4'hF, 4'hF, 1'b1, 5'h1F, 5'h1F, 1'b1);
        step(4'h0, 4'h0, 1'b1, 5'b01000, 5'b00000, 1'b1);
        #2;
        apply_reset();
        step(4'hF, 4'hF, 1'b1, 5'h1F, 5'h1F, 1'b1);
        step(4'hF, 4'hF, 1'b1, 5'h1F, 5'h1F, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hpdcache_arb_mux.md
# hpdcache_arb_mux

Parametrised N-input arbitrated multiplexer with valid/ready handshakes, multi-beat transfer locking and a one-entry registered output stage. Selects one requester per cycle (fixed-priority or round-robin), forwards its payload to a single downstream channel and returns the grant as a one-hot selector alongside the data. Used wherever several HPDcache request or refill sources share one downstream port, such as miss-handler and write-buffer requests toward the memory interface.

## Interface
- NINPUT, 2: number of requesters; 1 is legal and degenerates to a registered pass-through.
- DATA_WIDTH, 64: payload width per input, in bits.
- RR_ARB, 1: 1 = round-robin arbitration; 0 = fixed priority, where the lowest index wins.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- req_valid_i  input  NINPUT  per-input request valid.
- req_ready_o  output  NINPUT  per-input ready; one-hot or all-zero.
- req_data_i  input  NINPUT x DATA_WIDTH  per-input payload, packed array.
- req_last_i  input  NINPUT  marks the last beat of a transfer; 0 locks the grant to that input.
- out_valid_o  output  1  output register holds a beat.
- out_ready_i  input  1  downstream accepts the beat.
- out_data_o  output  DATA_WIDTH  registered payload.
- out_last_o  output  1  registered last flag.
- out_sel_o  output  NINPUT  registered one-hot index of the source input.

## Operation
- Load enable: `load_en = !out_valid_o || out_ready_i`. The register accepts a new beat when it is empty or is being drained in the same cycle.
- Candidate set:
  - When `lock` is set, the candidates are `req_valid_i & (1 << lock_idx)`.
  - Otherwise, the candidates are `req_valid_i`.
- Fixed priority (RR_ARB=0): the lowest-index candidate wins.
- Round-robin (RR_ARB=1): scan from index `ptr` upward, modulo NINPUT; the first candidate wins.
- Grant and ready:
  - `req_ready_o[k] = load_en && (winner == k)`.
  - If there are no candidates, `req_ready_o` is all-zero.
  - Ready depends combinationally on `req_valid_i` and `out_ready_i`; valid must not depend on ready.
- Beat accepted (`req_valid_i[k] && req_ready_o[k]`):
  - `out_data_o <= req_data_i[k]`, `out_last_o <= req_last_i[k]`, `out_sel_o <= onehot(k)`, `out_valid_o <= 1`.
- Lock handling on an accepted beat:
  - If `req_last_i[k] == 0`: set `lock <= 1` and `lock_idx <= k`.
  - If `req_last_i[k] == 1`: clear `lock`, and when RR_ARB=1 update `ptr <= (k+1) mod NINPUT`, wrapping from NINPUT-1 to 0.
- Pointer stability: `ptr` is not updated on non-last beats, so a locked transfer does not move round-robin fairness.
- Drain with no new load (`out_ready_i && !accept`): `out_valid_o <= 0`. out_data_o, out_last_o and out_sel_o hold their last values; they are don't-care while invalid.
- Stall (`out_valid_o && !out_ready_i`): all output registers hold, req_ready_o is all-zero and no arbitration state changes.
- Locked input deasserts valid mid-transfer: the lock holds and other inputs are starved until the locked input delivers a last beat. This is intended; requesters must not abandon a transfer.
- NINPUT == 1: no arbitration; ptr and lock_idx are constant 0.
- Pointer width is max(1, $clog2(NINPUT)). Non-power-of-two NINPUT must wrap at NINPUT, never at 2^width.

## Timing
- Latency: a beat accepted in cycle t appears on out_*_o in cycle t+1.
- Throughput: one beat per cycle while out_ready_i stays high.
- Reset (asynchronous assert, synchronous-safe deassert via rst_ni): out_valid_o=0, out_data_o=0, out_last_o=0, out_sel_o=0, ptr=0, lock=0, lock_idx=0.
- Outputs during reset: req_ready_o is all-ones-capable as soon as rst_ni deasserts, since the register is empty.
- Reset mid-transfer: both the lock and the held beat are discarded; upstream sources are responsible for restarting.
- No combinational path from req_* to out_*_o.

## Test plan
- Fixed priority, NINPUT=4, RR_ARB=0:
  - Stimulus: all inputs valid with last=1 and data=0xA0+k; out_ready_i held at 1.
  - Required response: out_sel_o=0001 every cycle, out_data_o=0xA0, and req_ready_o=0001 from cycle 1.
- Round-robin fairness, NINPUT=3, RR_ARB=1:
  - Stimulus: all inputs continuously valid with last=1.
  - Required response: out_sel_o sequence 001, 010, 100, 001; ptr wraps 2→0.
- Lock:
  - Stimulus: input 2 sends 3 beats with last=0,0,1 while input 0 stays valid.
  - Required response: out_sel_o=100 for 3 consecutive beats, then input 0 is granted and ptr=0 (RR).
- Backpressure:
  - Stimulus: out_ready_i=0 for 5 cycles with out_valid_o=1 and input 1 valid.
  - Required response: out_data_o stable, req_ready_o=0; on the first cycle with ready=1, input 1 is accepted in the same cycle with no bubble.
- Reset:
  - Stimulus: assert rst_ni low mid-locked-transfer.
  - Required response: out_valid_o drops to 0 without waiting for a clock edge; after release, input 0 wins under full contention.
- Non-power-of-two wrap:
  - Stimulus: NINPUT=5; a last beat is accepted from input 4.
  - Required response: ptr=0, never 5/6/7; the next grant goes to the lowest valid index ≥0.
